// File: rtl/pipe_adder.sv
// pipe_adder -- pipelined ripple-carry adder.
//
// The WIDTH-bit add is split into STAGES slices of SLICE = WIDTH/STAGES bits.
// Each clock adds one slice and registers its carry for the next stage. The
// upper operand slices that are still unprocessed travel alongside, and the
// finished lower sum slices are passed down the pipe. Each stage has one valid
// bit. A single enable advances the whole pipe, so a stalled output freezes
// every stage.
//
// Parameters
//   WIDTH   operand/sum width (WIDTH % STAGES must be 0)
//   STAGES  pipeline depth / number of carry slices (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   a/b/cin (and sub) valid this cycle
//   in_ready   pipe accepts input this cycle
//   a, b       operands (unsigned or two's complement)
//   cin        carry into slice 0
//   sub        only with PIPE_ADDER_SUB_EN: 1 => a - b (cin ignored)
//   out_valid  sum/cout/ovf valid
//   out_ready  downstream accepts the result this cycle
//   sum        a + b + cin mod 2^WIDTH
//   cout       carry out of the MSB (with sub: 1 => no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//
// Build option: define PIPE_ADDER_SUB_EN to add the sub port.

module pipe_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SLICE = (STAGES == 0) ? WIDTH : WIDTH / STAGES;

  if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH (%0d) must be a nonzero multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  logic             en;
  logic             sub_i;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

`ifdef PIPE_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  // Subtraction is resolved at the input as a + ~b + 1. Only the inverted
  // operand and the forced carry travel down the pipe, so no stage needs a
  // separate sub bit.
  assign b_eff = sub_i ? ~b : b;
  assign c_eff = sub_i ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unprocessed when they enter this stage.
    localparam int unsigned WIN = WIDTH - k * SLICE;

    logic [WIN-1:0]           ain;
    logic [WIN-1:0]           bin;
    logic                     ci;
    logic                     vi;
    logic [SLICE:0]           part;
    logic [(k+1)*SLICE-1:0]   snext;
    logic [(k+1)*SLICE-1:0]   s_r;
    logic                     c_r;
    logic                     v_r;

    if (k == 0) begin : g_src
      assign ain   = a;
      assign bin   = b_eff;
      assign ci    = c_eff;
      assign vi    = in_valid;
      assign snext = part[SLICE-1:0];
    end else begin : g_src
      assign ain   = g_stage[k-1].g_fwd.a_r;
      assign bin   = g_stage[k-1].g_fwd.b_r;
      assign ci    = g_stage[k-1].c_r;
      assign vi    = g_stage[k-1].v_r;
      assign snext = {part[SLICE-1:0], g_stage[k-1].s_r};
    end

    assign part = {1'b0, ain[SLICE-1:0]} + {1'b0, bin[SLICE-1:0]}
                + {{SLICE{1'b0}}, ci};

    // Data registers load only for a valid slot. Bubbles still move the
    // valid bit, and the output registers keep their last result.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (en) begin
        v_r <= vi;
        if (vi) begin
          c_r <= part[SLICE];
          s_r <= snext;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIN-SLICE-1:0] a_r;
      logic [WIN-SLICE-1:0] b_r;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (en && vi) begin
          a_r <= ain[WIN-1:SLICE];
          b_r <= bin[WIN-1:SLICE];
        end
      end
    end else begin : g_last
      logic ovf_r;
      logic c_msb;

      // Carry into the MSB is recovered from the MSB sum bit:
      // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
      assign c_msb = ain[SLICE-1] ^ bin[SLICE-1] ^ part[SLICE-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (en && vi) begin
          ovf_r <= c_msb ^ part[SLICE];
        end
      end

      assign out_valid = v_r;
      assign sum       = s_r;
      assign cout      = c_r;
      assign ovf       = ovf_r;
    end
  end

endmodule
